// File: rtl/fifo_uart_tx_pkg.sv
// Shared UART TX definitions: FSM states, frame constants and the parity helper.
package fifo_uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int unsigned DATA_BITS = 8;
    localparam logic        TXD_IDLE  = 1'b1;

    // Parity bit for a data byte; odd=1 selects odd parity.
    function automatic logic frame_parity(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_cnt.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1, wraps on tick, held at 0 while cleared.
module uart_baud_cnt #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o,
    output logic near_o
);

    localparam int unsigned      CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRELAST = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // tick marks the final clock of a bit; near marks the clock before it
    assign tick_o = (cnt_q == LAST);
    assign near_o = (cnt_q == PRELAST);

    // Next count: restart at every bit boundary or while cleared
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    // Count register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops show-ahead FIFO bytes and sends them as UART frames on txd.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_en,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_rd,
    output logic        txd,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] byte_count
);

    tx_state_e      state_q, state_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic           parity_q, parity_d;
    logic           stop_idx_q, stop_idx_d;
    logic           txd_q, txd_d;
    logic           done_q, done_d;
    logic [15:0]    count_q, count_d;
    logic           pop;
    logic           last_stop;
    logic           baud_tick;
    logic           baud_near;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (state_q == ST_IDLE),
        .tick_o(baud_tick),
        .near_o(baud_near)
    );

    assign last_stop  = (STOP_BITS < 2) || stop_idx_q;
    assign fifo_rd    = pop;
    assign busy       = (state_q != ST_IDLE) || pop;
    assign txd        = txd_q;
    assign frame_done = done_q;
    assign byte_count = count_q;

    // Next-state, pop decode and registered line value
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        parity_d   = parity_q;
        stop_idx_d = stop_idx_q;
        count_d    = count_q;
        pop        = 1'b0;
        txd_d      = TXD_IDLE;

        unique case (state_q)
            ST_IDLE: begin
                pop = tx_en & ~fifo_empty & ~rst;
                if (pop) begin
                    shift_d  = fifo_data;
                    parity_d = frame_parity(fifo_data, PARITY_ODD != 0);
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        state_d    = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (baud_tick) begin
                    state_d    = ST_STOP;
                    stop_idx_d = 1'b0;
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (last_stop) begin
                        state_d = ST_IDLE;
                        count_d = count_q + 16'd1;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // txd is registered, so it is decoded from the state being entered
        unique case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_d[bit_idx_d];
            ST_PARITY: txd_d = parity_d;
            default:   txd_d = TXD_IDLE;
        endcase

        // frame_done is registered one clock early so it lands on the final stop clock
        done_d = (state_q == ST_STOP) && last_stop && baud_near;
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            parity_q   <= 1'b0;
            stop_idx_q <= 1'b0;
            txd_q      <= TXD_IDLE;
            done_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            parity_q   <= parity_d;
            stop_idx_q <= stop_idx_d;
            txd_q      <= txd_d;
            done_q     <= done_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three parameter sets driven in parallel from shared stimulus,
// each checked cycle by cycle against a frame-level model fed by its own FIFO queue.
module tb_fifo_uart_tx;

    localparam int unsigned CPB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_en;
    logic        push_v;
    logic [7:0]  push_b;
    logic        chk_en;
    logic [2:0]  quiet_all;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ch0: 8N1, ch1: 8E1, ch2: 8O2
    for (genvar g = 0; g < 3; g++) begin : g_ch
        localparam int unsigned PE = (g == 0) ? 0 : 1;
        localparam int unsigned PO = (g == 2) ? 1 : 0;
        localparam int unsigned SB = (g == 2) ? 2 : 1;

        logic        fifo_empty = 1'b1;
        logic [7:0]  fifo_data  = 8'h00;
        logic        fifo_rd, txd, busy, frame_done;
        logic [15:0] byte_count;
        logic [7:0]  fq[$];
        logic        eq[$];
        logic [15:0] cnt_m = 16'h0000;
        logic        quiet = 1'b1;

        fifo_uart_tx #(
            .CLKS_PER_BIT(CPB),
            .PARITY_EN   (PE),
            .PARITY_ODD  (PO),
            .STOP_BITS   (SB)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .tx_en     (tx_en),
            .fifo_empty(fifo_empty),
            .fifo_data (fifo_data),
            .fifo_rd   (fifo_rd),
            .txd       (txd),
            .busy      (busy),
            .frame_done(frame_done),
            .byte_count(byte_count)
        );

        assign quiet_all[g] = quiet;

        // Model: eq holds the expected txd value for each upcoming clock of the frame
        always @(posedge clk) begin
            logic       pop;
            logic [7:0] b;
            pop = (eq.size() == 0) && tx_en && (fq.size() != 0) && !rst;
            if (rst) begin
                eq.delete();
                cnt_m = 16'h0000;
            end else begin
                if (eq.size() != 0) begin
                    if (eq.size() == 1) cnt_m = cnt_m + 16'd1;
                    void'(eq.pop_front());
                end
                if (pop) begin
                    b = fq.pop_front();
                    for (int unsigned i = 0; i < CPB; i++) eq.push_back(1'b0);
                    for (int unsigned k = 0; k < 8; k++)
                        for (int unsigned i = 0; i < CPB; i++) eq.push_back(b[k]);
                    if (PE != 0)
                        for (int unsigned i = 0; i < CPB; i++) eq.push_back((^b) ^ (PO != 0));
                    for (int unsigned i = 0; i < SB * CPB; i++) eq.push_back(1'b1);
                end
            end
            if (push_v) fq.push_back(push_b);
            fifo_empty <= (fq.size() == 0);
            fifo_data  <= (fq.size() != 0) ? fq[0] : 8'h00;
            quiet      <= (eq.size() == 0) && (fq.size() == 0);
        end

        // Mid-cycle comparison of every output against the model
        always @(negedge clk) begin
            if (chk_en) begin
                logic exp_rd;
                exp_rd = (eq.size() == 0) && tx_en && (fq.size() != 0) && !rst;
                check_eq($sformatf("ch%0d txd", g), 32'(txd), 32'((eq.size() != 0) ? eq[0] : 1'b1));
                check_eq($sformatf("ch%0d fifo_rd", g), 32'(fifo_rd), 32'(exp_rd));
                check_eq($sformatf("ch%0d rd_on_empty", g), 32'(fifo_rd & fifo_empty), 32'd0);
                check_eq($sformatf("ch%0d busy", g), 32'(busy), 32'((eq.size() != 0) || exp_rd));
                check_eq($sformatf("ch%0d frame_done", g), 32'(frame_done), 32'(eq.size() == 1));
                check_eq($sformatf("ch%0d byte_count", g), 32'(byte_count), 32'(cnt_m));
            end
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        push_v = 1'b1;
        push_b = b;
        tick(1);
        push_v = 1'b0;
    endtask

    task automatic wait_quiet(input string tag);
        int unsigned n = 0;
        tick(2);
        while (quiet_all != 3'b111 && n < 6000) begin
            tick(1);
            n++;
        end
        check_eq({tag, " drained"}, 32'(quiet_all == 3'b111), 32'd1);
    endtask

    initial begin
        rst    = 1'b1;
        tx_en  = 1'b1;
        push_v = 1'b0;
        push_b = 8'h00;
        chk_en = 1'b0;

        // Reset held with a non-empty FIFO and tx_en high: no pop allowed
        tick(1);
        chk_en = 1'b1;
        push_byte(8'hA5);
        tick(2);
        rst = 1'b0;

        // Single byte 0xA5
        wait_quiet("single");

        // Three queued bytes, back to back
        tx_en = 1'b0;
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        tx_en = 1'b1;
        wait_quiet("burst3");

        // Parity pattern byte
        push_byte(8'h07);
        wait_quiet("parity");

        // tx_en dropped during data bit 3 with bytes still queued
        tx_en = 1'b0;
        push_byte(8'h3C);
        push_byte(8'h55);
        push_byte(8'h66);
        tx_en = 1'b1;
        tick(18);
        tx_en = 1'b0;
        tick(150);
        tx_en = 1'b1;
        wait_quiet("tx_en_drop");

        // Reset pulse around data bit 5
        push_byte(8'h5A);
        push_byte(8'h99);
        tick(24);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        wait_quiet("rst_mid");

        // Random traffic, tx_en toggling and occasional resets
        for (int unsigned c = 0; c < 4000; c++) begin
            push_v = ($urandom_range(0, 59) == 0);
            push_b = 8'($urandom);
            if ($urandom_range(0, 59) == 0) tx_en = ~tx_en;
            rst = ($urandom_range(0, 799) == 0);
            tick(1);
        end
        push_v = 1'b0;
        rst    = 1'b0;
        tx_en  = 1'b1;
        wait_quiet("random");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
